iob_line_responder: RTL and testbench

Responder (slave) end of the 256-bit valid/ready/rvalid line interface used between requesters, the bus controller and the cache. It accepts line-wide read and byte-strobed write requests, stores them in an on-chip line memory, and returns read data in order after a fixed pipeline latency. It serves as a backing store behind the cache, and as a standalone responder for exercising initiators and the bus controller in simulation and on FPGA.

---
 rtl/iob_resp_pkg.sv | 23 ++
 rtl/iob_line_responder_if.sv | 36 +++
 rtl/iob_resp_lfsr.sv | 39 +++
 rtl/iob_line_responder.sv | 112 +++++++++++
 tb/tb_iob_line_responder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_resp_pkg.sv
// ============================================================================
// Module : iob_resp_pkg
// Brief  : Shared constants and helpers for the line responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package iob_resp_pkg;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 8;

    // Feedback taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit on bits 0,2,3,5
    localparam logic [15:0] LFSR_TAP_MASK     = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_line_responder_if.sv
// ============================================================================
// Module : iob_line_responder_if
// Brief  : 256-bit valid/ready/rvalid line request/response bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface iob_line_responder_if
    import iob_resp_pkg::*;
#(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 256
);
    localparam int unsigned STRB_W = strb_w(DATA_W);

    logic              req_valid_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic [STRB_W-1:0] req_wstrb_i;
    logic              req_ready_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_rvalid_o;

    modport master (
        output req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i,
        input  req_ready_o, rsp_rdata_o, rsp_rvalid_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i,
        output req_ready_o, rsp_rdata_o, rsp_rvalid_o
    );

endinterface

`default_nettype wire

// File: rtl/iob_resp_lfsr.sv
// ============================================================================
// Module : iob_resp_lfsr
// Brief  : 16-bit Fibonacci LFSR with enable; exposes the upcoming state.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iob_resp_lfsr
    import iob_resp_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        en,
    output logic      [15:0] state_next
);

    logic [15:0] r_state;
    logic        w_feedback;

    if (SEED == 16'h0000) begin : g_bad_seed
        $error("iob_resp_lfsr: SEED must be nonzero");
    end

    assign w_feedback = ^(r_state & LFSR_TAP_MASK);
    assign state_next = {w_feedback, r_state[15:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else if (en) begin
            r_state <= state_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/iob_line_responder.sv
// ============================================================================
// Module : iob_line_responder
// Brief  : Line-memory responder with fixed-latency in-order read pipeline.
//          Optional pseudo-random backpressure under IOB_RESP_THROTTLE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iob_line_responder
    import iob_resp_pkg::*;
#(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned MEM_AW    = 10,
    parameter int unsigned RD_LAT    = 2,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  wire logic          clk_i,
    input  wire logic          arst_i,
    iob_line_responder_if.slave bus
);

    localparam int unsigned STRB_W = strb_w(DATA_W);
    localparam int unsigned DEPTH  = 1 << MEM_AW;

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("iob_line_responder: RD_LAT out of range 1..8");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_ready;
    logic              w_ready_next;
    logic              w_accept;
    logic              w_is_read;
    logic              w_is_write;
    logic [MEM_AW-1:0] w_idx;
    logic              w_unused_addr_hi;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [DATA_W-1:0] r_pipe_data [RD_LAT];

    // Upper address bits alias onto the stored lines
    assign w_idx            = bus.req_addr_i[MEM_AW-1:0];
    assign w_unused_addr_hi = ^bus.req_addr_i[ADDR_W-1:MEM_AW];

    assign w_accept   = bus.req_valid_i && r_ready;
    assign w_is_read  = w_accept && (bus.req_wstrb_i == '0);
    assign w_is_write = w_accept && (bus.req_wstrb_i != '0);

`ifdef IOB_RESP_THROTTLE_EN
    logic [15:0] w_lfsr_next;

    iob_resp_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk_i),
        .rst        (arst_i),
        .en         (1'b1),
        .state_next (w_lfsr_next)
    );

    assign w_ready_next = (w_lfsr_next[1:0] != 2'b00);
`else
    assign w_ready_next = 1'b1;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_ready_next;
        end
    end

    // Line memory is deliberately unreset
    always_ff @(posedge clk_i) begin
        if (w_is_write) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (bus.req_wstrb_i[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= bus.req_wdata_i[i*8 +: 8];
                end
            end
        end
    end

    // The output stage only loads on a valid arrival so rdata holds between pulses
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < int'(RD_LAT); k++) begin
                r_pipe_data[k] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_is_read;
            if (w_is_read) begin
                r_pipe_data[0] <= r_mem[w_idx];
            end
            for (int k = 1; k < int'(RD_LAT); k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                if ((k < int'(RD_LAT) - 1) || r_pipe_vld[k-1]) begin
                    r_pipe_data[k] <= r_pipe_data[k-1];
                end
            end
        end
    end

    assign bus.req_ready_o  = r_ready;
    assign bus.rsp_rvalid_o = r_pipe_vld[RD_LAT-1];
    assign bus.rsp_rdata_o  = r_pipe_data[RD_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_iob_line_responder.sv
// ============================================================================
// Module : tb_iob_line_responder
// Brief  : Scoreboard bench with a line-memory reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_iob_line_responder;
    import iob_resp_pkg::*;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned MEM_AW = 10;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iob_line_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iob_line_responder #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_AW    (MEM_AW),
        .RD_LAT    (RD_LAT),
        .LFSR_SEED (SEED)
    ) dut (
        .clk_i  (clk),
        .arst_i (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] ref_mem [int];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    int                edges   = 0;
    logic [DATA_W-1:0] last_rdata = '0;
    logic [15:0]       ref_lfsr = SEED;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return (s >> 1) | ({15'b0, b} << 15);
    endfunction

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < int'(DATA_W / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: memory indexed by address modulo line count, bytewise merge
    task automatic model_accept(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input logic [STRB_W-1:0] s);
        int idx;
        logic [DATA_W-1:0] line;
        exp_t e;
        idx  = int'(a) % (1 << MEM_AW);
        line = ref_mem.exists(idx) ? ref_mem[idx] : 'x;
        if (s == '0) begin
            e.data = line;
            e.cyc  = cyc + int'(RD_LAT);
            sb.push_back(e);
        end else begin
            for (int i = 0; i < int'(STRB_W); i++)
                if (s[i]) line[i*8 +: 8] = d[i*8 +: 8];
            ref_mem[idx] = line;
        end
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [STRB_W-1:0] s);
        int guard;
        guard = 0;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_wdata_i = d;
        bus.req_wstrb_i = s;
        while (bus.req_ready_o !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: ready=%b expected 1 within 64 cycles", bus.req_ready_o);
        end else begin
            model_accept(a, d, s);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_valid_i = 1'b0;
        bus.req_wstrb_i = '0;
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edges    <= 0;
            ref_lfsr <= SEED;
        end else begin
            edges    <= edges + 1;
            ref_lfsr <= lfsr_step(ref_lfsr);
        end
    end

    always @(negedge clk) begin : monitor
        logic exp_rdy;
        exp_t e;
        if (!rst) begin
`ifdef IOB_RESP_THROTTLE_EN
            exp_rdy = (edges > 0) && (ref_lfsr[1:0] != 2'b00);
`else
            exp_rdy = (edges > 0);
`endif
            check("ready", DATA_W'(bus.req_ready_o), DATA_W'(exp_rdy));
            if (bus.rsp_rvalid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rvalid: got rvalid=1 expected no pending read");
                end else begin
                    e = sb.pop_front();
                    check("rdata", bus.rsp_rdata_o, e.data);
                    check("rsp_cycle", DATA_W'(cyc), DATA_W'(e.cyc));
                end
                last_rdata = bus.rsp_rdata_o;
            end else begin
                check("rdata_hold", bus.rsp_rdata_o, last_rdata);
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_rvalid: got none by cycle %0d expected at cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] x_line;
        logic [DATA_W-1:0] y_line;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_wstrb_i = '0;

        repeat (2) @(negedge clk);
        check("reset_ready", DATA_W'(bus.req_ready_o), '0);
        check("reset_rvalid", DATA_W'(bus.rsp_rvalid_o), '0);
        check("reset_rdata", bus.rsp_rdata_o, '0);
        #2 rst = 1'b0;
        #1 check("ready_before_edge", DATA_W'(bus.req_ready_o), '0);
        @(negedge clk);

        // Full-line write and read-back
        issue(19'd5, {32{8'hA5}}, '1);
        issue(19'd5, '0, '0);
        idle(4);

        // Partial strobe merge
        issue(19'd3, {32{8'h11}}, '1);
        issue(19'd3, {32{8'h22}}, 32'h0000_000F);
        issue(19'd3, '0, '0);
        idle(4);

        // Back-to-back reads
        for (int i = 0; i < 4; i++) issue(ADDR_W'(i), rand_line(), '1);
        for (int i = 0; i < 4; i++) issue(ADDR_W'(i), '0, '0);
        idle(4);

        // Aliasing, write-then-read and read-then-write hazards
        x_line = rand_line();
        y_line = rand_line();
        issue(ADDR_W'((1 << MEM_AW) + 7), x_line, '1);
        issue(19'd7, '0, '0);
        issue(19'd7, '0, '0);
        issue(19'd7, y_line, '1);
        issue(19'd7, '0, '0);
        idle(4);

        // Reset with two reads in flight: none may surface afterwards
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 19'd5;
        bus.req_wstrb_i = '0;
        @(posedge clk);
        #1 bus.req_addr_i = 19'd3;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_rvalid", DATA_W'(bus.rsp_rvalid_o), '0);
        check("midrst_rdata", bus.rsp_rdata_o, '0);
        check("midrst_ready", DATA_W'(bus.req_ready_o), '0);
        repeat (2) @(negedge clk);
        sb.delete();
        last_rdata = '0;
        #2 rst = 1'b0;
        #1 check("post_rst_ready", DATA_W'(bus.req_ready_o), '0);
        @(negedge clk);

        // Randomised traffic over 32 pre-initialised lines with aliased addresses
        for (int i = 0; i < 32; i++) issue(ADDR_W'(i), rand_line(), '1);
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                logic [ADDR_W-1:0] a;
                logic [STRB_W-1:0] s;
                a = ADDR_W'(($urandom_range(0, 511) << MEM_AW) | $urandom_range(0, 31));
                case ($urandom_range(0, 4))
                    0, 1:    s = '0;
                    2:       s = '1;
                    default: s = STRB_W'($urandom);
                endcase
                issue(a, rand_line(), s);
            end else begin
                idle(1);
            end
        end
        idle(int'(RD_LAT) + 3);

        check("scoreboard_empty", DATA_W'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
